luma_front_end: RTL

- Upstream feeder for the gray-code bit-plane (gcbp) stage of the stabilisation pipeline.
- Converts a raw YCbCr 4:2:2 pixel stream (DE/VSYNC framed) into the luma/line/frame control interface gcbp consumes: 9-bit luma, valid strobe, new-line and new-frame pulses, and line count.
- Optionally box-averages horizontally by H_DECIM.
- Crops to ACTIVE_WIDTH x ACTIVE_LINES and flags malformed frames.

---
 rtl/luma_front_end.sv | 134 +++++++++++++
 1 files changed

// File: rtl/luma_front_end.sv
// Front end for the gcbp stage: turns a DE/VSYNC framed YCbCr 4:2:2 stream into
// cropped, horizontally box-averaged luma with line/frame markers and an error flag.
module luma_front_end #(
    parameter int ACTIVE_WIDTH = 640,
    parameter int ACTIVE_LINES = 480,
    parameter int H_DECIM      = 2,
    parameter int LINE_CNT_W   = 9
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic [15:0]           i_pix_data,
    input  logic                  i_pix_de,
    input  logic                  i_vsync,
    output logic [8:0]            o_luma_data,
    output logic                  o_luma_data_valid,
    output logic                  o_new_line,
    output logic                  o_new_frame,
    output logic [LINE_CNT_W-1:0] o_line_cnt,
    output logic                  o_frame_err
);

    localparam int H_SHIFT = (H_DECIM == 4) ? 2 : (H_DECIM == 2) ? 1 : 0;
    localparam int ACC_W   = 8 + H_SHIFT;
    localparam int PX_W    = $clog2(ACTIVE_WIDTH + 1);
    localparam int LN_W    = $clog2(ACTIVE_LINES + 1);
    localparam logic [PX_W-1:0] AW_P = PX_W'(ACTIVE_WIDTH);
    localparam logic [LN_W-1:0] AL_P = LN_W'(ACTIVE_LINES);

    typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, IN_LINE} state_t;

    state_t           state;
    logic             vs_q;
    logic             de_q;
    logic             frame_pending;
    logic [LN_W-1:0]  lines_seen;
    logic [PX_W-1:0]  px;
    logic [ACC_W-1:0] acc;

    logic             vs_rise;
    logic             de_rise;
    logic             de_fall;
    logic             pending_eff;
    logic [LN_W-1:0]  lines_eff;
    logic             line_start;
    logic             take;
    logic [PX_W-1:0]  px_idx;
    logic [ACC_W-1:0] sum;
    logic             keep_px;
    logic             group_end;
    logic [7:0]       avg;
    logic             unused_chroma;

    // A vsync rise is folded in ahead of a same-cycle DE rise, so that line
    // starts as line 0 of the new frame.
    always_comb begin
        vs_rise       = i_vsync & ~vs_q;
        de_rise       = i_pix_de & ~de_q;
        de_fall       = ~i_pix_de & de_q;
        pending_eff   = frame_pending | vs_rise;
        lines_eff     = vs_rise ? '0 : lines_seen;
        line_start    = de_rise & (vs_rise | (state == WAIT_LINE))
                        & (pending_eff | (lines_eff < AL_P));
        take          = i_pix_de & (line_start | ((state == IN_LINE) & ~vs_rise));
        px_idx        = line_start ? '0 : px;
        sum           = (line_start ? '0 : acc) + ACC_W'(i_pix_data[7:0]);
        keep_px       = take & (px_idx < AW_P);
        group_end     = (int'(px_idx) % H_DECIM) == (H_DECIM - 1);
        avg           = 8'(sum >> H_SHIFT);
        unused_chroma = ^i_pix_data[15:8];
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state             <= WAIT_FRAME;
            vs_q              <= 1'b0;
            de_q              <= 1'b0;
            frame_pending     <= 1'b0;
            lines_seen        <= '0;
            px                <= '0;
            acc               <= '0;
            o_luma_data       <= '0;
            o_luma_data_valid <= 1'b0;
            o_new_line        <= 1'b0;
            o_new_frame       <= 1'b0;
            o_line_cnt        <= '0;
            o_frame_err       <= 1'b0;
        end else begin
            vs_q              <= i_vsync;
            de_q              <= i_pix_de;
            o_luma_data_valid <= 1'b0;
            o_new_line        <= 1'b0;
            o_new_frame       <= 1'b0;

            // Aborted line, or a frame that closed short of ACTIVE_LINES.
            if (vs_rise) begin
                if ((state == IN_LINE) || ((state != WAIT_FRAME) && (lines_seen < AL_P)))
                    o_frame_err <= 1'b1;
                frame_pending <= 1'b1;
                lines_seen    <= '0;
                state         <= WAIT_LINE;
            end

            if (line_start) begin
                state      <= IN_LINE;
                o_new_line <= 1'b1;
                lines_seen <= lines_eff + LN_W'(1);
                if (pending_eff) begin
                    o_new_frame   <= 1'b1;
                    o_line_cnt    <= '0;
                    frame_pending <= 1'b0;
                    o_frame_err   <= 1'b0;
                end else begin
                    o_line_cnt <= LINE_CNT_W'(lines_eff);
                end
            end else if ((state == IN_LINE) && !vs_rise && de_fall) begin
                state <= WAIT_LINE;
                if (px < AW_P)
                    o_frame_err <= 1'b1;
            end

            if (keep_px) begin
                px <= px_idx + PX_W'(1);
                if (group_end) begin
                    o_luma_data       <= {1'b0, avg};
                    o_luma_data_valid <= 1'b1;
                    acc               <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule
